// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
package timer_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Highest value of a units digit and of a tens digit
    localparam logic [3:0] DIG_MAX_UNITS = 4'd9;
    localparam logic [3:0] DIG_MAX_TENS  = 4'd5;

    // Four BCD digits of an MM:SS value, most significant first
    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_u;
        logic [3:0] sec_t;
        logic [3:0] sec_u;
    } mmss_t;

    // True when a {tens,units} BCD pair lies in 00..59
    function automatic logic bcd_pair_valid(input logic [7:0] v);
        return (v[7:4] <= DIG_MAX_TENS) && (v[3:0] <= DIG_MAX_UNITS);
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with wrap to MAX and a borrow output.
module bcd_down_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] q,
    output logic       borrow
);

    // A decrement arriving at zero is passed on to the next digit
    assign borrow = dec && (q == 4'd0);

    // Digit register: load wins over decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 4'd0;
        end else if (load) begin
            q <= load_val;
        end else if (dec) begin
            q <= (q == 4'd0) ? MAX : q - 4'd1;
        end
    end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// MM:SS BCD countdown sequencer: prescaler, load check, start/pause/stop FSM.
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned PRE_W    = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic       running,
    output logic       paused,
    output logic       done,
    output logic       load_err
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_t           state;
    state_t           state_next;
    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_next;
    logic             dig_load;
    mmss_t            dig_val;
    mmss_t            load_word;
    logic             err_next;
    logic             load_ok;
    logic             load_zero;
    logic             at_one;
    logic             tick;
    logic             b_su;
    logic             b_st;
    logic             b_mu;
    logic             b_mt;

    // Load value decode and zero-approach detect
    assign load_word = mmss_t'({load_mm, load_ss});
    assign load_ok   = bcd_pair_valid(load_mm) && bcd_pair_valid(load_ss);
    assign load_zero = (load_mm == 8'h00) && (load_ss == 8'h00);
    assign at_one    = ({min_t, min_u, sec_t, sec_u} == 16'h0001);

    // Count step: only when running and no stop/start owns the cycle
    assign tick = !stop && !start && (state == RUN) && (pre == PRE_LAST);

    // Digit chain, seconds units first; each borrow feeds the next decrement
    bcd_down_digit #(.MAX(DIG_MAX_UNITS)) u_sec_u (
        .clk(clk), .rst(rst), .load(dig_load), .load_val(dig_val.sec_u),
        .dec(tick), .q(sec_u), .borrow(b_su)
    );
    bcd_down_digit #(.MAX(DIG_MAX_TENS)) u_sec_t (
        .clk(clk), .rst(rst), .load(dig_load), .load_val(dig_val.sec_t),
        .dec(b_su), .q(sec_t), .borrow(b_st)
    );
    bcd_down_digit #(.MAX(DIG_MAX_UNITS)) u_min_u (
        .clk(clk), .rst(rst), .load(dig_load), .load_val(dig_val.min_u),
        .dec(b_st), .q(min_u), .borrow(b_mu)
    );
    bcd_down_digit #(.MAX(DIG_MAX_TENS)) u_min_t (
        .clk(clk), .rst(rst), .load(dig_load), .load_val(dig_val.min_t),
        .dec(b_mu), .q(min_t), .borrow(b_mt)
    );

    // Next state, prescaler and digit load; priority stop > start > pause
    always_comb begin
        state_next = state;
        pre_next   = pre;
        dig_load   = 1'b0;
        dig_val    = '0;
        err_next   = 1'b0;

        if (stop) begin
            state_next = IDLE;
            pre_next   = '0;
            dig_load   = 1'b1;
        end else if (start) begin
            if (!load_ok) begin
                err_next = 1'b1;
                if (state == DONE) state_next = IDLE;
            end else if (load_zero) begin
                if (state == DONE) state_next = IDLE;
            end else begin
                state_next = RUN;
                pre_next   = '0;
                dig_load   = 1'b1;
                dig_val    = load_word;
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (tick) begin
                        pre_next = '0;
                        // min_t borrow can only fire on a corrupted count; end it cleanly
                        if (at_one || b_mt) begin
                            state_next = DONE;
                        end else if (pause) begin
                            state_next = PAUSE;
                        end
                    end else begin
                        pre_next = pre + PRE_W'(1);
                        if (pause) state_next = PAUSE;
                    end
                end
                PAUSE: begin
                    if (pause) state_next = RUN;
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    // State, prescaler and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pre      <= '0;
            running  <= 1'b0;
            paused   <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_next;
            pre      <= pre_next;
            running  <= (state_next == RUN);
            paused   <= (state_next == PAUSE);
            done     <= (state == DONE);
            load_err <= err_next;
        end
    end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench for countdown_timer_ctrl against a seconds-based reference model.
module tb_countdown_timer_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] load_mm = 8'h00;
    logic [7:0] load_ss = 8'h00;
    logic [3:0] min_t, min_u, sec_t, sec_u;
    logic       running, paused, done, load_err;

    countdown_timer_ctrl #(.TICK_DIV(TD), .PRE_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
        .load_mm(load_mm), .load_ss(load_ss),
        .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
        .running(running), .paused(paused), .done(done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [15:0] dig;
        logic       run;
        logic       pau;
        logic       dn;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: remaining time in whole seconds, mode as a small integer
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_rem = 0;
    int m_mode = M_IDLE;
    int m_pre = 0;
    logic m_done = 1'b0;
    logic m_err = 1'b0;

    function automatic logic pair_ok(input logic [7:0] v);
        int t = int'(v) / 16;
        int u = int'(v) % 16;
        return (t <= 5) && (u <= 9);
    endfunction

    function automatic int pair_val(input logic [7:0] v);
        return (int'(v) / 16) * 10 + (int'(v) % 16);
    endfunction

    function automatic logic [15:0] rem_digits(input int r);
        int m = r / 60;
        int s = r % 60;
        logic [3:0] a = 4'(m / 10);
        logic [3:0] b = 4'(m % 10);
        logic [3:0] c = 4'(s / 10);
        logic [3:0] d = 4'(s % 10);
        return {a, b, c, d};
    endfunction

    task automatic model_edge(input logic r, input logic st, input logic pa, input logic sp,
                              input logic [7:0] mm, input logic [7:0] ss);
        int val;
        if (r) begin
            m_rem = 0; m_mode = M_IDLE; m_pre = 0; m_done = 1'b0; m_err = 1'b0;
            return;
        end
        m_done = (m_mode == M_DONE);
        m_err  = 1'b0;
        val    = pair_val(mm) * 60 + pair_val(ss);
        if (sp) begin
            m_mode = M_IDLE; m_rem = 0; m_pre = 0;
        end else if (st) begin
            if (!(pair_ok(mm) && pair_ok(ss))) begin
                m_err = 1'b1;
                if (m_mode == M_DONE) m_mode = M_IDLE;
            end else if (val == 0) begin
                if (m_mode == M_DONE) m_mode = M_IDLE;
            end else begin
                m_rem = val; m_pre = 0; m_mode = M_RUN;
            end
        end else if (m_mode == M_RUN) begin
            if (m_pre == TD - 1) begin
                m_pre = 0;
                m_rem = m_rem - 1;
                if (m_rem == 0) m_mode = M_DONE;
                else if (pa) m_mode = M_PAUSE;
            end else begin
                m_pre = m_pre + 1;
                if (pa) m_mode = M_PAUSE;
            end
        end else if (m_mode == M_PAUSE) begin
            if (pa) m_mode = M_RUN;
        end else if (m_mode == M_DONE) begin
            m_mode = M_IDLE;
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, queue the expectation
    task automatic step(input logic r, input logic st, input logic pa, input logic sp,
                        input logic [7:0] mm, input logic [7:0] ss);
        exp_t e;
        rst = r; start = st; pause = pa; stop = sp; load_mm = mm; load_ss = ss;
        @(posedge clk);
        cyc = cyc + 1;
        model_edge(r, st, pa, sp, mm, ss);
        e.cyc = cyc;
        e.dig = rem_digits(m_rem);
        e.run = (m_mode == M_RUN);
        e.pau = (m_mode == M_PAUSE);
        e.dn  = m_done;
        e.err = m_err;
        sb.push_back(e);
        #1;
        rst = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, load_mm, load_ss);
    endtask

    task automatic go(input logic [7:0] mm, input logic [7:0] ss);
        step(1'b0, 1'b1, 1'b0, 1'b0, mm, ss);
    endtask

    // Monitor: every registered output set after an edge is checked against its queued entry
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [15:0] got;
            e = sb.pop_front();
            got = {min_t, min_u, sec_t, sec_u};
            n_checks = n_checks + 1;
            if (got !== e.dig || running !== e.run || paused !== e.pau ||
                done !== e.dn || load_err !== e.err) begin
                n_fail = n_fail + 1;
                $display("FAIL cycle %0d outputs: got dig=%h run=%b pau=%b done=%b err=%b, expected dig=%h run=%b pau=%b done=%b err=%b",
                         e.cyc, got, running, paused, done, load_err,
                         e.dig, e.run, e.pau, e.dn, e.err);
            end
        end
    end

    initial begin
        logic [7:0] mm, ss;
        int unsigned r;

        // Reset, then a short countdown through DONE
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        go(8'h00, 8'h03);
        idle(16);

        // Full borrow chain across minutes
        go(8'h01, 8'h00);
        idle(5);
        go(8'h10, 8'h00);
        idle(5);

        // Pause mid-prescale, hold, resume
        go(8'h00, 8'h09);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h09);
        idle(20);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h09);
        idle(6);

        // Invalid loads and the silent 00:00 start
        go(8'h00, 8'h6A);
        go(8'h60, 8'h00);
        go(8'h00, 8'h00);
        idle(2);
        go(8'h00, 8'h30);
        idle(3);
        go(8'h00, 8'h5A);
        idle(2);

        // stop and start together in RUN
        go(8'h00, 8'h30);
        idle(5);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h05);
        idle(3);

        // Tick and pause together at 00:01
        go(8'h00, 8'h01);
        idle(3);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01);
        idle(3);

        // Reset while running
        go(8'h05, 8'h00);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 999);
            if ($urandom_range(0, 7) == 0) begin
                mm = 8'($urandom_range(0, 255));
                ss = 8'($urandom_range(0, 255));
            end else begin
                mm = {4'd0, 4'($urandom_range(0, 2))};
                ss = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            end
            step(r < 5, (r >= 5 && r < 45) || r >= 990, (r >= 100 && r < 170) || r >= 985,
                 (r >= 45 && r < 70) || r >= 995, mm, ss);
        end

        @(negedge clk);
        #1;
        n_checks = n_checks + 1;
        if (sb.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
